fifo_port_arbiter: RTL and testbench

//  Shares one DEPTH-entry synchronous FIFO between two requesters, each issuing write or read commands.
//  - Selects at most one command per cycle, round-robin.
//  - Pre-checks full/empty against a shadow count; drives the FIFO's wr_en/rd_en/din.
//  - Routes read data back to the winning requester one cycle after the FIFO read.

---
 rtl/fifo_port_arbiter_pkg.sv | 22 ++
 rtl/fifo_port_arbiter_if.sv | 32 +++
 rtl/fifo_port_arbiter_rr_pick2.sv | 15 +
 rtl/fifo_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_fifo_port_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_port_arbiter_pkg.sv
// rtl/fifo_port_arbiter_pkg.sv - shared state codes and opcodes for the FIFO port arbiter
// Purpose: state encodings (identical to the FIFO controller codes), command opcodes
//          and a legality check for the state register.
// Ports:   none (package).
package fifo_port_arbiter_pkg;

   typedef logic [2:0] arb_state_t;

   localparam arb_state_t ARB_IDLE     = 3'b000;
   localparam arb_state_t ARB_WRITE    = 3'b001;
   localparam arb_state_t ARB_READ     = 3'b010;
   localparam arb_state_t ARB_WR_ERROR = 3'b011;
   localparam arb_state_t ARB_RD_ERROR = 3'b100;

   localparam logic OP_WRITE = 1'b0;
   localparam logic OP_READ  = 1'b1;

   function automatic logic is_legal_state(input arb_state_t s);
      return s <= ARB_RD_ERROR;
   endfunction

endpackage

// File: rtl/fifo_port_arbiter_if.sv
// rtl/fifo_port_arbiter_if.sv - requester and FIFO-side bundle of the FIFO port arbiter
// Purpose: groups both requester command/response channels and the FIFO port.
// Ports:   slave  - arbiter side (takes requests and fifo_dout, drives pulses and FIFO controls)
//          master - client/FIFO side (drives requests and fifo_dout, observes the rest)
interface fifo_port_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 4
);
   logic              req0, req1;
   logic              op0, op1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1;
   logic              err0, err1;
   logic              rvalid0, rvalid1;
   logic [DATA_W-1:0] rdata;
   logic              fifo_wr_en, fifo_rd_en;
   logic [DATA_W-1:0] fifo_din;
   logic [DATA_W-1:0] fifo_dout;
   logic [CNT_W-1:0]  count;

   modport slave (
      input  req0, req1, op0, op1, wdata0, wdata1, fifo_dout,
      output gnt0, gnt1, err0, err1, rvalid0, rvalid1, rdata,
             fifo_wr_en, fifo_rd_en, fifo_din, count
   );

   modport master (
      output req0, req1, op0, op1, wdata0, wdata1, fifo_dout,
      input  gnt0, gnt1, err0, err1, rvalid0, rvalid1, rdata,
             fifo_wr_en, fifo_rd_en, fifo_din, count
   );
endinterface

// File: rtl/fifo_port_arbiter_rr_pick2.sv
// rtl/fifo_port_arbiter_rr_pick2.sv - two-way round-robin pick
// Purpose: picks one of two eligible requesters; on a tie the one not served last wins.
// Ports:   elig_i[1:0]  eligible requesters
//          rr_last_i    requester served by the previous grant or error
//          win_valid_o  some requester won
//          win_id_o     index of the winner
module rr_pick2 (
   input  logic [1:0] elig_i,
   input  logic       rr_last_i,
   output logic       win_valid_o,
   output logic       win_id_o
);
   assign win_valid_o = |elig_i;
   assign win_id_o    = (&elig_i) ? ~rr_last_i : elig_i[1];
endmodule

// File: rtl/fifo_port_arbiter.sv
// rtl/fifo_port_arbiter.sv - two-requester round-robin arbiter in front of one FIFO
// Purpose: issues at most one write/read per cycle into a shared DEPTH-entry FIFO,
//          rejecting writes when full and reads when empty using a shadow count,
//          and returns read data to the requester that issued the read.
// Ports:   clk      rising-edge clock
//          reset_n  asynchronous active-low reset
//          bus      requester commands/responses and FIFO wr_en/rd_en/din/dout, count
module fifo_port_arbiter
   import fifo_port_arbiter_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   fifo_port_arbiter_if.slave  bus
);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   arb_state_t        state_q, state_d;
   logic              owner_q, owner_d;
   logic              rr_last_q, rr_last_d;
   logic              rd_owner_q, rd_owner_d;
   logic [1:0]        rvalid_q, rvalid_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] din_q, din_d;

   logic [1:0]        gnt, err, elig;
   logic              wr_en, rd_en;
   logic              win_valid, win_id, win_op;
   logic [DATA_W-1:0] win_wdata;

   // The registered state plus its owner fully describe this cycle's action.
   always_comb begin
      gnt   = 2'b00;
      err   = 2'b00;
      wr_en = 1'b0;
      rd_en = 1'b0;
      case (state_q)
         ARB_IDLE: ;
         ARB_WRITE: begin
            gnt[owner_q] = 1'b1;
            wr_en        = 1'b1;
         end
         ARB_READ: begin
            gnt[owner_q] = 1'b1;
            rd_en        = 1'b1;
         end
         ARB_WR_ERROR, ARB_RD_ERROR: err[owner_q] = 1'b1;
         default: begin
            gnt   = 'x;
            err   = 'x;
            wr_en = 'x;
            rd_en = 'x;
         end
      endcase
   end

   // A requester is still holding req during its gnt/err cycle; that stale cycle is masked.
   assign elig = {bus.req1 & ~gnt[1] & ~err[1], bus.req0 & ~gnt[0] & ~err[0]};

   rr_pick2 u_pick (
      .elig_i      (elig),
      .rr_last_i   (rr_last_q),
      .win_valid_o (win_valid),
      .win_id_o    (win_id)
   );

   assign win_op    = win_id ? bus.op1 : bus.op0;
   assign win_wdata = win_id ? bus.wdata1 : bus.wdata0;

   // Count is updated at the decision edge so the next decision already sees it;
   // this hides the FIFO's own one-cycle flag lag.
   always_comb begin
      state_d    = ARB_IDLE;
      owner_d    = owner_q;
      rr_last_d  = rr_last_q;
      rd_owner_d = rd_owner_q;
      count_d    = count_q;
      din_d      = din_q;
      if (win_valid && is_legal_state(state_q)) begin
         owner_d   = win_id;
         rr_last_d = win_id;
         if (win_op == OP_WRITE) begin
            if (count_q == DEPTH_C) begin
               state_d = ARB_WR_ERROR;
            end else begin
               state_d = ARB_WRITE;
               count_d = count_q + ONE_C;
               din_d   = win_wdata;
            end
         end else begin
            if (count_q == '0) begin
               state_d = ARB_RD_ERROR;
            end else begin
               state_d    = ARB_READ;
               count_d    = count_q - ONE_C;
               rd_owner_d = win_id;
            end
         end
      end
   end

   always_comb begin
      rvalid_d = 2'b00;
      if (state_q == ARB_READ) rvalid_d[rd_owner_q] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ARB_IDLE;
         owner_q    <= 1'b0;
         rr_last_q  <= 1'b1;
         rd_owner_q <= 1'b0;
         rvalid_q   <= 2'b00;
         count_q    <= '0;
         din_q      <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_last_q  <= rr_last_d;
         rd_owner_q <= rd_owner_d;
         rvalid_q   <= rvalid_d;
         count_q    <= count_d;
         din_q      <= din_d;
      end
   end

   assign bus.gnt0       = gnt[0];
   assign bus.gnt1       = gnt[1];
   assign bus.err0       = err[0];
   assign bus.err1       = err[1];
   assign bus.rvalid0    = rvalid_q[0];
   assign bus.rvalid1    = rvalid_q[1];
   assign bus.rdata      = bus.fifo_dout;
   assign bus.fifo_wr_en = wr_en;
   assign bus.fifo_rd_en = rd_en;
   assign bus.fifo_din   = din_q;
   assign bus.count      = count_q;

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// tb/tb_fifo_port_arbiter.sv - directed vector bench for fifo_port_arbiter
module tb_fifo_port_arbiter;

   localparam logic W = 1'b0;
   localparam logic R = 1'b1;

   localparam logic [5:0] P_G1 = 6'b100000;
   localparam logic [5:0] P_G0 = 6'b010000;
   localparam logic [5:0] P_E1 = 6'b001000;
   localparam logic [5:0] P_E0 = 6'b000100;
   localparam logic [5:0] P_R1 = 6'b000010;
   localparam logic [5:0] P_R0 = 6'b000001;
   localparam logic [1:0] EN_WR = 2'b01;
   localparam logic [1:0] EN_RD = 2'b10;

   typedef struct {
      logic        rst_n;
      logic        req0, op0;
      logic [31:0] wd0;
      logic        req1, op1;
      logic [31:0] wd1;
      logic [5:0]  pulses;
      logic [1:0]  en;
      logic [31:0] din;
      logic        chk_rd;
      logic [31:0] rdata;
      logic [3:0]  count;
   } vec_t;

   logic clk;
   logic reset_n;
   int   checks;
   int   failures;
   vec_t vecs[$];

   fifo_port_arbiter_if #(.DATA_W(32), .CNT_W(4)) bus ();

   fifo_port_arbiter #(.DATA_W(32), .DEPTH(8), .CNT_W(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Stand-in for the attached 8-entry FIFO: data out one cycle after rd_en.
   logic [31:0] mem [0:7];
   logic [2:0]  wp, rp;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp            <= '0;
         rp            <= '0;
         bus.fifo_dout <= '0;
      end else begin
         if (bus.fifo_wr_en) begin
            mem[wp] <= bus.fifo_din;
            wp      <= wp + 3'd1;
         end
         if (bus.fifo_rd_en) begin
            bus.fifo_dout <= mem[rp];
            rp            <= rp + 3'd1;
         end
      end
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void add(input logic rst, input logic r0, input logic o0, input logic [31:0] w0,
                               input logic r1, input logic o1, input logic [31:0] w1,
                               input logic [5:0] p, input logic [1:0] en, input logic [31:0] din,
                               input logic ck, input logic [31:0] rd, input logic [3:0] cnt);
      vec_t v;
      v.rst_n = rst; v.req0 = r0; v.op0 = o0; v.wd0 = w0;
      v.req1 = r1; v.op1 = o1; v.wd1 = w1;
      v.pulses = p; v.en = en; v.din = din; v.chk_rd = ck; v.rdata = rd; v.count = cnt;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r0, input logic o0, input logic [31:0] w0,
                        input logic r1, input logic o1, input logic [31:0] w1);
      bus.req0 = r0; bus.op0 = o0; bus.wdata0 = w0;
      bus.req1 = r1; bus.op1 = o1; bus.wdata1 = w1;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] pulses();
      return {bus.gnt1, bus.gnt0, bus.err1, bus.err0, bus.rvalid1, bus.rvalid0};
   endfunction

   initial begin
      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      drive(0, 0, 0, 0, 0, 0);

      // Reset state
      add(0, 0, 0, 0, 0, 0, 0, 6'b0, 2'b0, 32'h0, 0, 0, 4'd0);
      // Read from empty -> err0, count stays 0
      add(1, 1, R, 0, 0, 0, 0, P_E0, 2'b0, 32'h0, 0, 0, 4'd0);
      add(1, 0, 0, 0, 0, 0, 0, 6'b0, 2'b0, 32'h0, 0, 0, 4'd0);
      // Fill with 0xA0..0xA7; req held through the gnt cycle is masked
      for (int i = 0; i < 8; i++) begin
         add(1, 1, W, 32'hA0 + i, 0, 0, 0, P_G0, EN_WR, 32'hA0 + i, 0, 0, 4'(i + 1));
         add(1, 1, W, 32'hA0 + i, 0, 0, 0, 6'b0, 2'b0, 32'hA0 + i, 0, 0, 4'(i + 1));
      end
      // Ninth write rejected, no FIFO write
      add(1, 1, W, 32'hA8, 0, 0, 0, P_E0, 2'b0, 32'hA7, 0, 0, 4'd8);
      add(1, 0, 0, 0, 0, 0, 0, 6'b0, 2'b0, 32'hA7, 0, 0, 4'd8);
      // Both write each cycle: grants alternate 0,1,0,1
      add(0, 0, 0, 0, 0, 0, 0, 6'b0, 2'b0, 32'h0, 0, 0, 4'd0);
      add(1, 1, W, 32'h11, 1, W, 32'h22, P_G0, EN_WR, 32'h11, 0, 0, 4'd1);
      add(1, 1, W, 32'h11, 1, W, 32'h22, P_G1, EN_WR, 32'h22, 0, 0, 4'd2);
      add(1, 1, W, 32'h11, 1, W, 32'h22, P_G0, EN_WR, 32'h11, 0, 0, 4'd3);
      add(1, 1, W, 32'h11, 1, W, 32'h22, P_G1, EN_WR, 32'h22, 0, 0, 4'd4);
      add(1, 0, 0, 0, 0, 0, 0, 6'b0, 2'b0, 32'h22, 0, 0, 4'd4);
      // req1 read then req0 read: data routed to each owner a cycle later
      add(1, 0, 0, 0, 1, R, 0, P_G1, EN_RD, 32'h22, 0, 0, 4'd3);
      add(1, 1, R, 0, 0, 0, 0, P_G0 | P_R1, EN_RD, 32'h22, 1, 32'h11, 4'd2);
      add(1, 0, 0, 0, 0, 0, 0, P_R0, 2'b0, 32'h22, 1, 32'h22, 4'd2);
      // count 7, both write: rr winner (1, since 0 was served last) granted, other errors
      add(0, 0, 0, 0, 0, 0, 0, 6'b0, 2'b0, 32'h0, 0, 0, 4'd0);
      for (int i = 0; i < 7; i++) begin
         add(1, 1, W, 32'hB0 + i, 0, 0, 0, P_G0, EN_WR, 32'hB0 + i, 0, 0, 4'(i + 1));
         add(1, 0, 0, 0, 0, 0, 0, 6'b0, 2'b0, 32'hB0 + i, 0, 0, 4'(i + 1));
      end
      add(1, 1, W, 32'hC0, 1, W, 32'hC1, P_G1, EN_WR, 32'hC1, 0, 0, 4'd8);
      add(1, 1, W, 32'hC0, 1, W, 32'hC1, P_E0, 2'b0, 32'hC1, 0, 0, 4'd8);
      add(1, 0, 0, 0, 0, 0, 0, 6'b0, 2'b0, 32'hC1, 0, 0, 4'd8);
      // Back-to-back read then write when full
      add(1, 0, 0, 0, 1, R, 0, P_G1, EN_RD, 32'hC1, 0, 0, 4'd7);
      add(1, 1, W, 32'hC2, 0, 0, 0, P_G0 | P_R1, EN_WR, 32'hC2, 1, 32'hB0, 4'd8);
      add(1, 0, 0, 0, 0, 0, 0, 6'b0, 2'b0, 32'hC2, 0, 0, 4'd8);

      cyc();
      foreach (vecs[k]) begin
         reset_n = vecs[k].rst_n;
         drive(vecs[k].req0, vecs[k].op0, vecs[k].wd0, vecs[k].req1, vecs[k].op1, vecs[k].wd1);
         cyc();
         check($sformatf("v%0d_pulses", k), 32'(pulses()), 32'(vecs[k].pulses));
         check($sformatf("v%0d_en", k), 32'({bus.fifo_rd_en, bus.fifo_wr_en}), 32'(vecs[k].en));
         check($sformatf("v%0d_din", k), bus.fifo_din, vecs[k].din);
         check($sformatf("v%0d_count", k), 32'(bus.count), 32'(vecs[k].count));
         if (vecs[k].chk_rd) check($sformatf("v%0d_rdata", k), bus.rdata, vecs[k].rdata);
      end

      // Reset asserted mid-cycle right after a read is issued
      reset_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      cyc();
      reset_n = 1'b1;
      drive(1, W, 32'hD0, 0, 0, 0); cyc();
      drive(0, 0, 0, 0, 0, 0);      cyc();
      drive(1, W, 32'hD1, 0, 0, 0); cyc();
      drive(0, 0, 0, 0, 0, 0);      cyc();
      drive(1, R, 0, 0, 0, 0);      cyc();
      check("rst_read_issued_pulses", 32'(pulses()), 32'(P_G0));
      check("rst_read_issued_rd_en", 32'(bus.fifo_rd_en), 32'd1);
      check("rst_read_issued_count", 32'(bus.count), 32'd1);
      reset_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      #1;
      check("rst_async_pulses", 32'(pulses()), 32'd0);
      check("rst_async_count", 32'(bus.count), 32'd0);
      check("rst_async_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      cyc();
      check("rst_held_pulses", 32'(pulses()), 32'd0);
      check("rst_held_din", bus.fifo_din, 32'd0);
      reset_n = 1'b1;
      cyc();
      check("rst_released_pulses", 32'(pulses()), 32'd0);
      check("rst_released_en", 32'({bus.fifo_rd_en, bus.fifo_wr_en}), 32'd0);
      // First command after reset comes from requester 0 priority
      drive(1, W, 32'hE0, 1, W, 32'hE1); cyc();
      check("post_rst_rr_pulses", 32'(pulses()), 32'(P_G0));
      check("post_rst_rr_din", bus.fifo_din, 32'hE0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
